// File: rtl/imem_fetch_if.sv
// Fetch-side bus for imem_fetch: request handshake, response handshake and flush.
interface imem_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_instr;
  logic [ADDR_W-1:0] rsp_pc;
  logic [2:0]        rsp_fault;
  logic              flush;

  // Fetch stage side
  modport master (
    output req_valid, req_pc, rsp_ready, flush,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );

  // Instruction memory side
  modport slave (
    input  req_valid, req_pc, rsp_ready, flush,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );
endinterface

// File: rtl/imem_fetch.sv
// Synchronous instruction memory for the RV32I fetch stage.
// One-cycle registered response with fault flags (misaligned, out-of-range,
// parity), runtime word loader, and flush on redirect.
// Optional build macro: IMEM_PARITY_EN adds a stored even-parity bit per word.
module imem_fetch #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                           clk,
  input  logic                           reset,
  imem_fetch_if.slave                    bus,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data,
  input  logic                           ld_inject_err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned HI_LSB = IDX_W + 2;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              rsp_valid_q;
  logic [31:0]       rsp_instr_q;
  logic [ADDR_W-1:0] rsp_pc_q;
  logic [2:0]        rsp_fault_q;

  logic              req_ready_c;
  logic              accept_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [31:0]       rd_word_c;
  logic              misalign_c;
  logic              oor_c;
  logic              parity_err_c;
  logic [2:0]        fault_c;

  // Address decode of the incoming request
  assign rd_idx_c   = bus.req_pc[2 +: IDX_W];
  assign rd_word_c  = mem[rd_idx_c];
  assign misalign_c = |bus.req_pc[1:0];
  assign oor_c      = |bus.req_pc[ADDR_W-1:HI_LSB];

  // Loader stalls fetch so a read and a write never share a cycle
  assign req_ready_c = reset & ~ld_en & ~bus.flush & (~rsp_valid_q | bus.rsp_ready);
  assign accept_c    = bus.req_valid & req_ready_c;

  // Loader write port; contents survive reset
  always_ff @(posedge clk) begin
    if (reset && ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH_WORDS];

  // Parity bit captured alongside each loaded word
  always_ff @(posedge clk) begin
    if (reset && ld_en) begin
      par_mem[ld_addr] <= (^ld_data) ^ ld_inject_err;
    end
  end

  assign parity_err_c = (^rd_word_c) != par_mem[rd_idx_c];
`else
  logic unused_ld_inject_err;
  assign unused_ld_inject_err = ld_inject_err;
  assign parity_err_c         = 1'b0;
`endif

  // Parity is only meaningful on an access that actually reads the array
  assign fault_c = {parity_err_c & ~(misalign_c | oor_c), oor_c, misalign_c};

  // Response register: flush beats backpressure, accept overwrites with no bubble
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= 32'h0;
      rsp_pc_q    <= ADDR_W'(0);
      rsp_fault_q <= 3'b000;
    end else if (bus.flush) begin
      rsp_valid_q <= 1'b0;
    end else if (accept_c) begin
      rsp_valid_q <= 1'b1;
      rsp_pc_q    <= bus.req_pc;
      rsp_fault_q <= fault_c;
      rsp_instr_q <= (misalign_c | oor_c) ? NOP_WORD : rd_word_c;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_pc    = rsp_pc_q;
  assign bus.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: transaction-level model compared every cycle,
// plus directed literal expectations from the test plan.
module tb_imem_fetch;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  logic clk;
  logic reset;
  logic ld_en;
  logic [IDX_W-1:0] ld_addr;
  logic [31:0] ld_data;
  logic ld_inject_err;

  int total;
  int bad;

  imem_fetch_if #(.ADDR_W(ADDR_W)) bif ();

  imem_fetch #(
    .ADDR_W(ADDR_W),
    .DEPTH_WORDS(DEPTH),
    .NOP_WORD(32'h00000013)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif.slave),
    .ld_en(ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ld_inject_err(ld_inject_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_bad [DEPTH];
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [2:0]  m_fault;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i] = 32'h0;
      m_bad[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_pc    = 32'h0;
    m_fault = 3'b000;
  end

  function automatic bit m_ready();
    return reset && !ld_en && !bif.flush && (!m_valid || bif.rsp_ready);
  endfunction

  // What a fetch of pc must return, from the address rules alone
  function automatic logic [34:0] m_fetch(input logic [31:0] pc);
    logic [2:0]  f;
    logic [31:0] w;
    int unsigned idx;
    idx  = (pc / 4) % DEPTH;
    f[0] = (pc % 4) != 0;
    f[1] = pc >= DEPTH * 4;
    f[2] = 1'b0;
`ifdef IMEM_PARITY_EN
    f[2] = !f[0] && !f[1] && m_bad[idx];
`endif
    w = (f[0] || f[1]) ? 32'h00000013 : m_mem[idx];
    return {f, w};
  endfunction

  always @(posedge clk) begin
    logic [34:0] r;
    bit acc;
    acc = bif.req_valid && m_ready();
    r   = m_fetch(bif.req_pc);
    if (!reset) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_pc    = 32'h0;
      m_fault = 3'b000;
    end else begin
      if (ld_en) begin
        m_mem[ld_addr] = ld_data;
        m_bad[ld_addr] = ld_inject_err;
      end
      if (bif.flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_pc    = bif.req_pc;
        m_instr = r[31:0];
        m_fault = r[34:32];
      end else if (bif.rsp_ready) m_valid = 1'b0;
    end
  end

  // Compare every cycle once the first reset edge has passed
  bit cmp_on;
  initial cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_req_ready", 64'(bif.req_ready), 64'(m_ready()));
      chk("m_rsp_valid", 64'(bif.rsp_valid), 64'(m_valid));
      chk("m_rsp_instr", 64'(bif.rsp_instr), 64'(m_instr));
      chk("m_rsp_pc",    64'(bif.rsp_pc),    64'(m_pc));
      chk("m_rsp_fault", 64'(bif.rsp_fault), 64'(m_fault));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic rdy);
    bif.req_valid = 1'b1;
    bif.req_pc    = pc;
    bif.rsp_ready = rdy;
  endtask

  task automatic load(input logic [IDX_W-1:0] a, input logic [31:0] d, input logic inj);
    ld_en = 1'b1; ld_addr = a; ld_data = d; ld_inject_err = inj;
    tick();
    ld_en = 1'b0; ld_inject_err = 1'b0;
  endtask

  logic [2:0] exp_par;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_inject_err = 1'b0;
    bif.req_valid = 1'b0; bif.req_pc = '0; bif.rsp_ready = 1'b0; bif.flush = 1'b0;

    // Reset for two cycles
    tick();
    cmp_on = 1'b1;
    tick();
    chk("rst_valid", 64'(bif.rsp_valid), 64'(0));
    chk("rst_instr", 64'(bif.rsp_instr), 64'(0));
    chk("rst_fault", 64'(bif.rsp_fault), 64'(0));
    chk("rst_ready", 64'(bif.req_ready), 64'(0));
    reset = 1'b1;
    #1;
    chk("ready_after_rst", 64'(bif.req_ready), 64'(1));

    // Load two words and fetch back-to-back
    load(6'd0, 32'h00940333, 1'b0);
    load(6'd1, 32'h800100b3, 1'b0);
    fetch(32'h0, 1'b1);
    tick();
    chk("b2b0_instr", 64'(bif.rsp_instr), 64'h00940333);
    chk("b2b0_pc",    64'(bif.rsp_pc),    64'h0);
    fetch(32'h4, 1'b1);
    tick();
    chk("b2b1_instr", 64'(bif.rsp_instr), 64'h800100b3);
    chk("b2b1_pc",    64'(bif.rsp_pc),    64'h4);
    chk("b2b1_fault", 64'(bif.rsp_fault), 64'h0);
    bif.req_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(bif.rsp_valid), 64'(0));
    chk("drain_hold",  64'(bif.rsp_instr), 64'h800100b3);

    // Backpressure for three cycles, then release with a new accept
    fetch(32'h4, 1'b0);
    tick();
    fetch(32'h8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_instr", 64'(bif.rsp_instr), 64'h800100b3);
      chk("bp_ready", 64'(bif.req_ready), 64'(0));
      tick();
    end
    fetch(32'h0, 1'b1);
    #1;
    chk("bp_release_ready", 64'(bif.req_ready), 64'(1));
    tick();
    chk("bp_next_instr", 64'(bif.rsp_instr), 64'h00940333);
    chk("bp_next_valid", 64'(bif.rsp_valid), 64'(1));

    // Fault cases
    fetch(32'h6, 1'b1);
    tick();
    chk("mis_fault", 64'(bif.rsp_fault), 64'b001);
    chk("mis_instr", 64'(bif.rsp_instr), 64'h00000013);
    fetch(32'h400, 1'b1);
    tick();
    chk("oor_fault", 64'(bif.rsp_fault), 64'b010);
    chk("oor_instr", 64'(bif.rsp_instr), 64'h00000013);
    fetch(32'h401, 1'b1);
    tick();
    chk("both_fault", 64'(bif.rsp_fault), 64'b011);
    fetch(32'hfc, 1'b1);
    tick();
    chk("top_word_fault", 64'(bif.rsp_fault), 64'b000);
    bif.req_valid = 1'b0;
    tick();

    // Flush drops a stalled response and blocks acceptance
    fetch(32'h0, 1'b0);
    tick();
    chk("fl_pre_valid", 64'(bif.rsp_valid), 64'(1));
    fetch(32'h4, 1'b0);
    bif.flush = 1'b1;
    #1;
    chk("fl_ready", 64'(bif.req_ready), 64'(0));
    tick();
    bif.flush = 1'b0;
    bif.req_valid = 1'b0;
    chk("fl_valid", 64'(bif.rsp_valid), 64'(0));
    chk("fl_pc",    64'(bif.rsp_pc),    64'h0);
    tick();

    // Loader during a stalled response leaves it intact
    fetch(32'h4, 1'b0);
    tick();
    bif.req_valid = 1'b0;
    load(6'd1, 32'h11111111, 1'b0);
    chk("ld_hold_instr", 64'(bif.rsp_instr), 64'h800100b3);
    fetch(32'h4, 1'b1);
    tick();
    chk("ld_new_instr", 64'(bif.rsp_instr), 64'h11111111);
    bif.req_valid = 1'b0;
    tick();

    // Reset mid-response; memory retained, loader ignored during reset
    fetch(32'h4, 1'b0);
    tick();
    bif.req_valid = 1'b0;
    reset = 1'b0;
    ld_en = 1'b1; ld_addr = 6'd0; ld_data = 32'hffffffff;
    tick();
    ld_en = 1'b0;
    chk("mid_rst_valid", 64'(bif.rsp_valid), 64'(0));
    chk("mid_rst_instr", 64'(bif.rsp_instr), 64'(0));
    reset = 1'b1;
    fetch(32'h0, 1'b1);
    tick();
    chk("refetch_instr", 64'(bif.rsp_instr), 64'h00940333);
    bif.req_valid = 1'b0;
    tick();

    // Parity injection
    load(6'd2, 32'h00c54ab3, 1'b1);
    fetch(32'h8, 1'b1);
    tick();
`ifdef IMEM_PARITY_EN
    exp_par = 3'b100;
`else
    exp_par = 3'b000;
`endif
    chk("par_fault", 64'(bif.rsp_fault), 64'(exp_par));
    chk("par_instr", 64'(bif.rsp_instr), 64'h00c54ab3);
    bif.req_valid = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
